// File: rtl/ps2_rx_buf.sv
// PS/2 receiver with a byte FIFO that can be read at any offset from its head.
// Raw PS/2 lines are synchronized and glitch-filtered. A frame FSM then
// assembles the bytes and writes them into a DEPTH-entry FIFO.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, the odd parity of
// each frame is checked. A frame that fails is dropped and sets o_perr.
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | waiting for a start bit (sample of 0)
// ST_DATA    | shifting in 8 data bits, LSB first
// ST_PARITY  | capturing the parity bit
// ST_STOP    | stop bit: 1 accepts the frame, 0 discards it
module ps2_rx_buf #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ps2_clk,
  input  logic              i_ps2_data,
  input  logic              i_req,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_clr,
  output logic [7:0]        o_out,
  output logic              o_done,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_perr
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            filt_clk;
  logic [FC_W-1:0] filt_cnt;
  logic            smp_evt, smp_bit;
  state_t          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [WD_W-1:0] wd_cnt;
  logic            wr_pend;
  logic [7:0]      wr_byte;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_addr;
  logic            rd_hit, do_pop, do_wr;
`ifdef PS2_PARITY_CHECK_EN
  logic            par_bit, perr_set, perr_q;
`endif

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == FULL_CNT);
  assign rd_addr = rd_ptr + i_addr;
  assign rd_hit  = ({1'b0, i_addr} < o_count);
  assign do_pop  = i_req && i_pop && (i_addr == '0) && !o_empty && !i_clr;
  assign do_wr   = wr_pend && (!o_full || do_pop) && !i_clr;

  // Two-flop synchronizers on the raw PS/2 lines; idle level is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= i_ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= i_ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: flip only after FILT_LEN consecutive disagreeing samples; a filtered fall fires the sample event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      smp_evt  <= 1'b0;
      smp_bit  <= 1'b1;
    end else begin
      smp_evt <= 1'b0;
      smp_bit <= dat_s2;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        smp_evt  <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + FC_W'(1);
      end
    end
  end

  // Frame FSM with a watchdog down-counter; an accepted byte is handed to the FIFO one cycle later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      wd_cnt  <= WD_W'(TIMEOUT - 1);
      wr_pend <= 1'b0;
      wr_byte <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit  <= 1'b0;
      perr_set <= 1'b0;
`endif
    end else begin
      wr_pend <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      perr_set <= 1'b0;
`endif
      if (state == ST_IDLE || smp_evt) wd_cnt <= WD_W'(TIMEOUT - 1);
      else if (wd_cnt != '0)           wd_cnt <= wd_cnt - WD_W'(1);

      if (smp_evt) begin
        case (state)
          ST_IDLE: begin
            if (!smp_bit) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {smp_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= smp_bit;
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (smp_bit) begin
`ifdef PS2_PARITY_CHECK_EN
              if (^{shreg, par_bit}) begin
                wr_pend <= 1'b1;
                wr_byte <= shreg;
              end else begin
                perr_set <= 1'b1;
              end
`else
              wr_pend <= 1'b1;
              wr_byte <= shreg;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && wd_cnt == '0) begin
        state <= ST_IDLE;
      end
    end
  end

  // FIFO storage; no reset needed since o_count gates every read.
  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_byte;
  end

  // FIFO pointers, occupancy, read port and sticky flags; clear beats any same-cycle request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      o_count    <= '0;
      o_out      <= 8'h00;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      o_done <= i_req;
      if (i_req) o_out <= (!i_clr && rd_hit) ? mem[rd_addr] : 8'h00;
      if (i_clr) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        o_count    <= '0;
        o_overflow <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        perr_q     <= 1'b0;
`endif
      end else begin
        if (do_pop) rd_ptr <= rd_ptr + ADDR_W'(1);
        if (do_wr)  wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_pend && !do_wr) o_overflow <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
        if (perr_set) perr_q <= 1'b1;
`endif
        case ({do_wr, do_pop})
          2'b10:   o_count <= o_count + (ADDR_W+1)'(1);
          2'b01:   o_count <= o_count - (ADDR_W+1)'(1);
          default: o_count <= o_count;
        endcase
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign o_perr = perr_q;
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_buf.sv
// Scoreboard bench for ps2_rx_buf: every sent frame that should be stored is
// pushed to exp_q. Each read pops or indexes exp_q and compares the result.
module tb_ps2_rx_buf;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 4096;
  localparam int HALF     = 20;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_ps2_clk = 1'b1;
  logic              i_ps2_data = 1'b1;
  logic              i_req = 1'b0;
  logic              i_pop = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_clr = 1'b0;
  logic [7:0]        o_out;
  logic              o_done;
  logic [ADDR_W:0]   o_count;
  logic              o_empty, o_full, o_overflow, o_perr;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  ps2_rx_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ps2_clk(i_ps2_clk), .i_ps2_data(i_ps2_data),
    .i_req(i_req), .i_pop(i_pop), .i_addr(i_addr), .i_clr(i_clr),
    .o_out(o_out), .o_done(o_done), .o_count(o_count), .o_empty(o_empty),
    .o_full(o_full), .o_overflow(o_overflow), .o_perr(o_perr)
  );

  always #5 i_clk = ~i_clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clk);
  endtask

  task automatic ps2_bit(input logic b);
    i_ps2_data = b;
    wait_clk(HALF);
    i_ps2_clk = 1'b0;
    wait_clk(HALF);
    i_ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    ps2_bit(1'b1);
    wait_clk(4);
  endtask

  task automatic sb_send(input logic [7:0] d);
    send_frame(d, 1'b0);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  task automatic read_cycle(input logic [ADDR_W-1:0] a, input logic p, input logic c,
                            output logic [7:0] data, output logic done);
    @(negedge i_clk);
    i_req = 1'b1; i_pop = p; i_addr = a; i_clr = c;
    @(negedge i_clk);
    i_req = 1'b0; i_pop = 1'b0; i_addr = '0; i_clr = 1'b0;
    data = o_out;
    done = o_done;
  endtask

  task automatic test_reset;
    #2 i_rst = 1'b1;
    #1;
    n_cmp++; if (o_count !== 5'd0)  begin n_err++; $display("FAIL rst_count got %0d want 0", o_count); end
    n_cmp++; if (o_empty !== 1'b1)  begin n_err++; $display("FAIL rst_empty got %b want 1", o_empty); end
    n_cmp++; if (o_full !== 1'b0)   begin n_err++; $display("FAIL rst_full got %b want 0", o_full); end
    n_cmp++; if (o_out !== 8'h00)   begin n_err++; $display("FAIL rst_out got %h want 00", o_out); end
    n_cmp++; if (o_done !== 1'b0)   begin n_err++; $display("FAIL rst_done got %b want 0", o_done); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", o_overflow); end
    n_cmp++; if (o_perr !== 1'b0)   begin n_err++; $display("FAIL rst_perr got %b want 0", o_perr); end
    wait_clk(3);
    @(negedge i_clk) i_rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_single;
    logic [7:0] d; logic dn; logic [7:0] e;
    sb_send(8'h5C);
    n_cmp++; if (o_count !== 5'd1) begin n_err++; $display("FAIL single_count_before got %0d want 1", o_count); end
    e = exp_q.pop_front();
    read_cycle('0, 1'b1, 1'b0, d, dn);
    n_cmp++; if (dn !== 1'b1) begin n_err++; $display("FAIL single_done got %b want 1", dn); end
    n_cmp++; if (d !== e)     begin n_err++; $display("FAIL single_out got %h want %h", d, e); end
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL single_count_after got %0d want 0", o_count); end
  endtask

  task automatic test_offset;
    logic [7:0] d; logic dn; logic [7:0] e;
    sb_send(8'h79); sb_send(8'hC3); sb_send(8'hAE);
    e = exp_q[2];
    read_cycle(4'd2, 1'b0, 1'b0, d, dn);
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL offset_out got %h want %h", d, e); end
    n_cmp++; if (o_count !== 5'd3) begin n_err++; $display("FAIL offset_count got %0d want 3", o_count); end
    read_cycle(4'd3, 1'b1, 1'b0, d, dn);
    n_cmp++; if (dn !== 1'b1 || d !== 8'h00) begin n_err++; $display("FAIL oob_read got done=%b out=%h want done=1 out=00", dn, d); end
    read_cycle(4'd1, 1'b1, 1'b0, d, dn);
    n_cmp++; if (o_count !== 5'd3) begin n_err++; $display("FAIL pop_nonzero_addr count got %0d want 3", o_count); end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      read_cycle('0, 1'b1, 1'b0, d, dn);
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL offset_drain%0d got %h want %h", k, d, e); end
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i <= DEPTH; i++) sb_send(8'(8'h11 + i * 37));
    n_cmp++; if (o_full !== 1'b1)     begin n_err++; $display("FAIL ovf_full got %b want 1", o_full); end
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", o_overflow); end
    n_cmp++; if (o_count !== 5'(DEPTH)) begin n_err++; $display("FAIL ovf_count got %0d want %0d", o_count, DEPTH); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    @(negedge i_clk);
    i_req = 1'b1; i_pop = 1'b1; i_addr = '0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge i_clk);
      if (k == DEPTH - 1) begin i_req = 1'b0; i_pop = 1'b0; end
      e = exp_q.pop_front();
      n_cmp++;
      if (o_done !== 1'b1 || o_out !== e) begin
        n_err++; $display("FAIL b2b_read%0d got done=%b out=%h want done=1 out=%h", k, o_done, o_out, e);
      end
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b want 1", o_empty); end
  endtask

  task automatic test_clr_req;
    logic [7:0] d; logic dn;
    sb_send(8'h12);
    read_cycle('0, 1'b1, 1'b1, d, dn);
    exp_q.delete();
    n_cmp++; if (dn !== 1'b1 || d !== 8'h00) begin n_err++; $display("FAIL clr_req got done=%b out=%h want done=1 out=00", dn, d); end
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL clr_count got %0d want 0", o_count); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", o_overflow); end
  endtask

  task automatic test_parity;
    logic [7:0] d; logic dn; logic [7:0] e;
    send_frame(8'h3F, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL parity_count got %0d want 0", o_count); end
    n_cmp++; if (o_perr !== 1'b1)  begin n_err++; $display("FAIL parity_perr got %b want 1", o_perr); end
    read_cycle('0, 1'b0, 1'b1, d, dn);
    n_cmp++; if (o_perr !== 1'b0)  begin n_err++; $display("FAIL parity_clr got %b want 0", o_perr); end
`else
    exp_q.push_back(8'h3F);
    n_cmp++; if (o_perr !== 1'b0)  begin n_err++; $display("FAIL parity_perr got %b want 0", o_perr); end
    e = exp_q.pop_front();
    read_cycle('0, 1'b1, 1'b0, d, dn);
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL parity_stored got %h want %h", d, e); end
`endif
  endtask

  task automatic test_timeout;
    logic [7:0] d; logic dn; logic [7:0] e;
    logic [7:0] partial = 8'hA5;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(partial[i]);
    wait_clk(TIMEOUT + 10);
    sb_send(8'h5C);
    n_cmp++; if (o_count !== 5'd1) begin n_err++; $display("FAIL timeout_count got %0d want 1", o_count); end
    e = exp_q.pop_front();
    read_cycle('0, 1'b1, 1'b0, d, dn);
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL timeout_byte got %h want %h", d, e); end
  endtask

  task automatic test_reset_glitch;
    logic [7:0] d; logic dn; logic [7:0] e;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge i_clk) i_rst = 1'b1;
    wait_clk(3);
    @(negedge i_clk) i_rst = 1'b0;
    wait_clk(5);
    i_ps2_data = 1'b0;
    @(posedge i_clk) i_ps2_clk = 1'b0;
    @(posedge i_clk) i_ps2_clk = 1'b1;
    wait_clk(10);
    i_ps2_data = 1'b1;
    wait_clk(10);
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rstglitch_count got %0d want 0", o_count); end
    sb_send(8'h96);
    n_cmp++; if (o_count !== 5'd1) begin n_err++; $display("FAIL rstglitch_next_count got %0d want 1", o_count); end
    e = exp_q.pop_front();
    read_cycle('0, 1'b1, 1'b0, d, dn);
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL rstglitch_byte got %h want %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_offset();
    test_overflow();
    test_back_to_back();
    test_clr_req();
    test_parity();
    test_timeout();
    test_reset_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
